// File: rtl/gate_bist.sv
// gate_bist: BIST sequencer for a 2-input NOR gate.
// Drives all four {a,b} vectors, samples y after SETTLE_CYCLES and reports a failure map/count.
module gate_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS = 1,
  parameter logic [3:0] EXP_TABLE = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [7:0] err_cnt
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] loop_q, loop_d;
  logic [3:0] set_q, set_d;
  logic       done_q, done_d, pass_q, pass_d;
  logic [3:0] fail_q, fail_d;
  logic [7:0] err_q, err_d;
  logic       run, go, samp, mis, last, keep;
  always_comb begin
    run  = state_q == RUN;
    go   = !run && start && !abort;
    samp = run && !abort && set_q == 4'(SETTLE_CYCLES - 1);
    mis  = samp && y_i != EXP_TABLE[idx_q];
    last = samp && idx_q == 2'd3 && loop_q == 8'(LOOPS - 1);
    keep = run && !abort && !last;
    state_d = go ? RUN : (run && (abort || last)) ? IDLE : state_q;
    idx_d   = keep ? idx_q + {1'b0, samp} : 2'd0;
    loop_d  = keep ? loop_q + {7'd0, samp && idx_q == 2'd3} : 8'd0;
    set_d   = (run && !abort && !samp) ? set_q + 4'd1 : 4'd0;
    fail_d  = go ? 4'd0 : fail_q | (mis ? 4'd1 << idx_q : 4'd0);
    err_d   = go ? 8'd0 : (mis && err_q != 8'hff) ? err_q + 8'd1 : err_q;
    done_d  = last;
    pass_d  = (go || (run && abort)) ? 1'b0 : last ? err_d == 8'd0 : pass_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      loop_q  <= '0;
      set_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      set_q   <= set_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end
  // Vector index is forced to 0 whenever IDLE, so gating by busy keeps a/b low outside a run.
  assign busy     = state_q == RUN;
  assign a_o      = busy & idx_q[1];
  assign b_o      = busy & idx_q[0];
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_vec = fail_q;
  assign err_cnt  = err_q;
endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: directed checks of gate_bist with NOR, stuck-at and OR gate models.
module tb_gate_bist;
  logic clk = 0, rst_n = 0, start0 = 0, start1 = 0, abort = 0;
  logic [1:0] mode = 0;
  logic a0, b0, busy0, done0, pass0, y0;
  logic a1, b1, busy1, done1, pass1, y1;
  logic [3:0] fv0, fv1;
  logic [7:0] ec0, ec1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign y0 = mode == 2'd0 ? ~(a0 | b0) : mode == 2'd1 ? 1'b0 : mode == 2'd2 ? 1'b1 : (a0 | b0);
  assign y1 = a1 | b1;

  gate_bist dut0 (.clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .y_i(y0),
    .a_o(a0), .b_o(b0), .busy(busy0), .done(done0), .pass(pass0), .fail_vec(fv0), .err_cnt(ec0));
  gate_bist #(.SETTLE_CYCLES(1), .LOOPS(3)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1),
    .abort(abort), .y_i(y1), .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_vec(fv1), .err_cnt(ec1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick0();
    start0 = 1;
    step();
    start0 = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({a0, b0, busy0, done0, pass0, fv0, ec0} !== 17'd0) begin
      errors++; $display("FAIL reset0 got %b want 0", {a0, b0, busy0, done0, pass0, fv0, ec0});
    end
    checks++;
    if ({a1, b1, busy1, done1, pass1, fv1, ec1} !== 17'd0) begin
      errors++; $display("FAIL reset1 got %b want 0", {a1, b1, busy1, done1, pass1, fv1, ec1});
    end
    #10 rst_n = 1;
    step();
  endtask

  task automatic test_nor();
    mode = 0;
    kick0();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (busy0 !== 1'b1 || {a0, b0} !== 2'(k >> 1) || done0 !== 1'b0) begin
        errors++; $display("FAIL nor_seq k=%0d got busy=%b ab=%b done=%b want busy=1 ab=%0d done=0", k, busy0, {a0, b0}, done0, k >> 1);
      end
      step();
    end
    checks++;
    if ({busy0, done0, pass0, fv0, ec0, a0, b0} !== {3'b011, 4'd0, 8'd0, 2'b00}) begin
      errors++; $display("FAIL nor_end got busy=%b done=%b pass=%b fv=%b ec=%0d want 0 1 1 0000 0", busy0, done0, pass0, fv0, ec0);
    end
    step();
    checks++;
    if (done0 !== 1'b0 || pass0 !== 1'b1) begin
      errors++; $display("FAIL nor_pulse got done=%b pass=%b want done=0 pass=1", done0, pass0);
    end
  endtask

  task automatic test_stuck0();
    mode = 1;
    kick0();
    repeat (8) step();
    checks++;
    if ({done0, pass0, fv0, ec0} !== {2'b10, 4'b0001, 8'd1}) begin
      errors++; $display("FAIL stuck0 got done=%b pass=%b fv=%b ec=%0d want 1 0 0001 1", done0, pass0, fv0, ec0);
    end
    step();
  endtask

  task automatic test_or_loops();
    int cnt;
    cnt = 0;
    start1 = 1;
    step();
    start1 = 0;
    while (busy1 && cnt < 50) begin
      cnt++;
      step();
    end
    checks++;
    if (cnt !== 12) begin
      errors++; $display("FAIL or_busy got %0d cycles want 12", cnt);
    end
    checks++;
    if ({done1, pass1, fv1, ec1} !== {2'b10, 4'b1111, 8'd12}) begin
      errors++; $display("FAIL or_res got done=%b pass=%b fv=%b ec=%0d want 1 0 1111 12", done1, pass1, fv1, ec1);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int cnt;
    mode = 0;
    start0 = 1;
    cnt = 0;
    while (!done0 && cnt < 50) begin
      cnt++;
      step();
    end
    checks++;
    if (!done0) begin
      errors++; $display("FAIL b2b_first got no done want done");
    end
    for (int r = 0; r < 2; r++) begin
      if (r == 1) start0 = 1;
      cnt = 0;
      step();
      cnt++;
      while (!done0 && cnt < 50) begin
        step();
        cnt++;
      end
      if (r == 1) start0 = 0;
      checks++;
      if (cnt !== 9 || pass0 !== 1'b1) begin
        errors++; $display("FAIL b2b_period r=%0d got %0d pass=%b want 9 pass=1", r, cnt, pass0);
      end
    end
    start0 = 0;
    step();
    checks++;
    if (busy0 !== 1'b0) begin
      errors++; $display("FAIL b2b_stop got busy=%b want 0", busy0);
    end
  endtask

  task automatic test_abort();
    mode = 2;
    kick0();
    repeat (4) step();
    abort = 1;
    step();
    abort = 0;
    checks++;
    if ({busy0, a0, b0, done0, pass0, fv0, ec0} !== {5'b0, 4'b0010, 8'd1}) begin
      errors++; $display("FAIL abort got busy=%b ab=%b done=%b pass=%b fv=%b ec=%0d want 0 00 0 0 0010 1", busy0, {a0, b0}, done0, pass0, fv0, ec0);
    end
    repeat (6) begin
      step();
      checks++;
      if (done0 !== 1'b0 || ec0 !== 8'd1 || busy0 !== 1'b0) begin
        errors++; $display("FAIL abort_hold got done=%b ec=%0d busy=%b want 0 1 0", done0, ec0, busy0);
      end
    end
    start0 = 1;
    abort = 1;
    step();
    start0 = 0;
    abort = 0;
    checks++;
    if (busy0 !== 1'b0 || ec0 !== 8'd1) begin
      errors++; $display("FAIL abort_start got busy=%b ec=%0d want 0 1", busy0, ec0);
    end
  endtask

  task automatic test_async_reset();
    int cnt;
    mode = 1;
    kick0();
    repeat (3) step();
    checks++;
    if (ec0 !== 8'd1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL rst_pre got ec=%0d busy=%b want 1 1", ec0, busy0);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({a0, b0, busy0, done0, pass0, fv0, ec0} !== 17'd0) begin
      errors++; $display("FAIL rst_async got %b want 0", {a0, b0, busy0, done0, pass0, fv0, ec0});
    end
    #3 rst_n = 1;
    mode = 0;
    step();
    kick0();
    cnt = 0;
    while (busy0 && cnt < 50) begin
      cnt++;
      step();
    end
    checks++;
    if (cnt !== 8 || pass0 !== 1'b1 || done0 !== 1'b1 || ec0 !== 8'd0) begin
      errors++; $display("FAIL rst_rerun got cycles=%0d pass=%b done=%b ec=%0d want 8 1 1 0", cnt, pass0, done0, ec0);
    end
  endtask

  initial begin
    test_reset();
    test_nor();
    test_stuck0();
    test_or_loops();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
